// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO; optional madd via MD_MADD_EN.
// Latency: MULT_CYCLES (mult/multu/madd) or DIV_CYCLES (div/divu); mthi/mtlo 1 edge.
// Backpressure: busy holds dependent ops in D; start while busy is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   tmp_hi, tmp_hi_nxt;
    logic [31:0]   tmp_lo, tmp_lo_nxt;
    logic          commit, commit_nxt;
    logic [31:0]   hi_nxt, lo_nxt;

    // Products: extend to 64 bits first so the truncated product is exact.
    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] mul_s, mul_u;

    assign a_sx  = {{32{a[31]}}, a};
    assign b_sx  = {{32{b[31]}}, b};
    assign a_zx  = {32'd0, a};
    assign b_zx  = {32'd0, b};
    assign mul_s = a_sx * b_sx;
    assign mul_u = a_zx * b_zx;

    // Signed divide on magnitudes; 0x80000000/-1 falls out as quotient 0x80000000.
    // Zero divisor is replaced by 1 to keep the datapath defined; commit is suppressed.
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_div;
    logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    assign a_neg  = a[31];
    assign b_neg  = b[31];
    assign b_zero = (b == 32'd0);
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_zero ? 32'd1 : (b_neg ? (32'd0 - b) : b);
    assign b_div  = b_zero ? 32'd1 : b;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quo_s  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem_s  = a_neg ? (32'd0 - r_mag) : r_mag;
    assign quo_u  = a / b_div;
    assign rem_u  = a % b_div;

`ifdef MD_MADD_EN
    logic [63:0] madd_sum;
    assign madd_sum = {hi, lo} + mul_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            commit <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            tmp_hi <= tmp_hi_nxt;
            tmp_lo <= tmp_lo_nxt;
            commit <= commit_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        tmp_hi_nxt = tmp_hi;
        tmp_lo_nxt = tmp_lo;
        commit_nxt = commit;
        hi_nxt     = hi;
        lo_nxt     = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {tmp_hi_nxt, tmp_lo_nxt} = mul_s;
                            count_nxt  = CW'(MULT_CYCLES);
                            commit_nxt = 1'b1;
                            state_nxt  = RUN;
                        end
                        OP_MULTU: begin
                            {tmp_hi_nxt, tmp_lo_nxt} = mul_u;
                            count_nxt  = CW'(MULT_CYCLES);
                            commit_nxt = 1'b1;
                            state_nxt  = RUN;
                        end
                        OP_DIV: begin
                            tmp_hi_nxt = rem_s;
                            tmp_lo_nxt = quo_s;
                            count_nxt  = CW'(DIV_CYCLES);
                            commit_nxt = !b_zero;
                            state_nxt  = RUN;
                        end
                        OP_DIVU: begin
                            tmp_hi_nxt = rem_u;
                            tmp_lo_nxt = quo_u;
                            count_nxt  = CW'(DIV_CYCLES);
                            commit_nxt = !b_zero;
                            state_nxt  = RUN;
                        end
                        OP_MTHI: hi_nxt = a;
                        OP_MTLO: lo_nxt = a;
`ifdef MD_MADD_EN
                        OP_MADD: begin
                            {tmp_hi_nxt, tmp_lo_nxt} = madd_sum;
                            count_nxt  = CW'(MULT_CYCLES);
                            commit_nxt = 1'b1;
                            state_nxt  = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    if (commit) begin
                        hi_nxt = tmp_hi;
                        lo_nxt = tmp_lo;
                    end
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (honours MD_MADD_EN).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecs = 0;
    int errs = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle start strobe; returns at the negedge of the first cycle after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = '0; b = '0;
    endtask

    // Counts busy cycles from now until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int errs_loop;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        errs_loop = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vecs++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                errs++;
                $display("FAIL reset_idle cyc=%0d busy=%b hi=%h lo=%h expected 0/0/0", i, busy, hi, lo);
            end
        end
        issue(3'd5, 32'h55, 32'd0);
        vecs++;
        if (hi !== 32'h55) begin
            errs++;
            $display("FAIL mthi_pre hi=%h expected 00000055", hi);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        vecs++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL async_reset hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int n;
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        vecs++;
        if (n !== 5) begin
            errs++;
            $display("FAIL mult_busy cycles=%0d expected 5", n);
        end
        vecs++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            errs++;
            $display("FAIL mult hi=%h lo=%h expected ffffffff/fffffffe", hi, lo);
        end
        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        vecs++;
        if (n !== 5 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            errs++;
            $display("FAIL multu cycles=%0d hi=%h lo=%h expected 5 00000001/fffffffe", n, hi, lo);
        end
    endtask

    task automatic test_div;
        int n;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        vecs++;
        if (n !== 10) begin
            errs++;
            $display("FAIL div_busy cycles=%0d expected 10", n);
        end
        vecs++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errs++;
            $display("FAIL div_neg hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
        end
        issue(3'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        vecs++;
        if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
            errs++;
            $display("FAIL div_negdivisor hi=%h lo=%h expected 00000001/fffffffd", hi, lo);
        end
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        vecs++;
        if (n !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
            errs++;
            $display("FAIL divu cycles=%0d hi=%h lo=%h expected 10 00000001/00000003", n, hi, lo);
        end
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        vecs++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            errs++;
            $display("FAIL div_overflow hi=%h lo=%h expected 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_divzero;
        int n;
        issue(3'd5, 32'hABCD, 32'd0);
        issue(3'd6, 32'h1234, 32'd0);
        vecs++;
        if (lo !== 32'h1234 || hi !== 32'hABCD || busy !== 1'b0) begin
            errs++;
            $display("FAIL mthi_mtlo hi=%h lo=%h busy=%b expected 0000abcd/00001234/0", hi, lo, busy);
        end
        issue(3'd4, 32'd5, 32'd0);
        wait_idle(n);
        vecs++;
        if (n !== 10) begin
            errs++;
            $display("FAIL divzero_busy cycles=%0d expected 10", n);
        end
        vecs++;
        if (hi !== 32'hABCD || lo !== 32'h1234) begin
            errs++;
            $display("FAIL divzero_hold hi=%h lo=%h expected 0000abcd/00001234", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = '0;
        wait_idle(n);
        vecs++;
        if (n !== 3) begin
            errs++;
            $display("FAIL ignore_busy remaining=%0d expected 3", n);
        end
        vecs++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            errs++;
            $display("FAIL ignore_start hi=%h lo=%h expected 00000000/0000000c", hi, lo);
        end
        issue(3'd5, 32'h77, 32'd0);
        issue(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL abort hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        vecs++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_late hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
        end
    endtask

    task automatic test_noop;
        issue(3'd6, 32'h0BAD, 32'd0);
        issue(3'd0, 32'hFFFF, 32'hFFFF);
        vecs++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h0BAD) begin
            errs++;
            $display("FAIL op_none busy=%b hi=%h lo=%h expected 0/00000000/00000bad", busy, hi, lo);
        end
    endtask

    task automatic test_madd;
        int n;
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd6, 32'hFFFFFFFF, 32'd0);
        issue(3'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        wait_idle(n);
        vecs++;
        if (n !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
            errs++;
            $display("FAIL madd cycles=%0d hi=%h lo=%h expected 5 00000001/00000000", n, hi, lo);
        end
`else
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL madd_off_busy busy=%b expected 0", busy);
        end
        wait_idle(n);
        repeat (6) @(negedge clk);
        vecs++;
        if (n !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            errs++;
            $display("FAIL madd_off cycles=%0d hi=%h lo=%h expected 0 00000000/ffffffff", n, hi, lo);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_divzero;
        test_back_to_back;
        test_noop;
        test_madd;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
